// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the lab I/O conditioning blocks.
// Holds the debounce FSM encoding and board clock constants.
package lab_io_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;

endpackage

// File: rtl/switch_debounce_if.sv
// Bundle of raw switch inputs and their conditioned outputs.
// master drives raw inputs; slave is the debouncer.
interface switch_debounce_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;

  modport master (
    output raw,
    input  level,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  raw,
    output level,
    output rise_pulse,
    output fall_pulse
  );

endinterface

// File: rtl/switch_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability FSM,
// registered level and single-cycle edge pulses.
module debounce_ch
  import lab_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  // s1 is the only flop that sees the asynchronous input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE_LO;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      unique case (state)
        IDLE_LO: begin
          if (s2) begin
            state <= WAIT_HI;
            cnt   <= ONE;
          end
        end
        WAIT_HI: begin
          if (!s2) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state      <= IDLE_HI;
            cnt        <= '0;
            level      <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        IDLE_HI: begin
          if (!s2) begin
            state <= WAIT_LO;
            cnt   <= ONE;
          end
        end
        WAIT_LO: begin
          if (s2) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state      <= IDLE_LO;
            cnt        <= '0;
            level      <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch/button conditioner for the lab datapaths.
// Each bit of raw gets its own independent debounce channel.
module switch_debounce
  import lab_io_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic               clock,
  input logic               reset_n,
  switch_debounce_if.slave  io
);

  logic [N_CH-1:0] lvl;
  logic [N_CH-1:0] rp;
  logic [N_CH-1:0] fp;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .raw       (io.raw[i]),
      .level     (lvl[i]),
      .rise_pulse(rp[i]),
      .fall_pulse(fp[i])
    );
  end

  assign io.level      = lvl;
  assign io.rise_pulse = rp;
  assign io.fall_pulse = fp;

endmodule
